hack_rom_loader: RTL and testbench

- Instruction-memory stage directly upstream of the Hack CPU. It owns the 32K x 16 instruction ROM, fills it from the MiSTer HPS ioctl byte stream, and serves `instruction` for the CPU's `pc`.
- It sequences CPU reset around downloads: the CPU is held in reset while a program loads and is released only after a fixed flush period.

---
 rtl/hack_rom_loader_if.sv | 21 ++
 rtl/hack_rom_loader.sv | 122 ++++++++++++
 tb/tb_hack_rom_loader.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/hack_rom_loader_if.sv
// hack_rom_loader_if: ioctl download stream and CPU fetch port of the Hack ROM loader.
interface hack_rom_loader_if #(parameter int ADDR_W = 15);
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       instruction;
    logic              cpu_reset;
    logic              load_done;
    logic [15:0]       word_count;
    logic              overflow;
    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, pc,
        input  instruction, cpu_reset, load_done, word_count, overflow
    );
    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, pc,
        output instruction, cpu_reset, load_done, word_count, overflow
    );
endinterface

// File: rtl/hack_rom_loader.sv
// hack_rom_loader: Hack instruction ROM filled from the ioctl byte stream, sequencing CPU reset around downloads.
module hack_rom_loader #(
    parameter int ADDR_W       = 15,
    parameter int DEPTH        = 32768,
    parameter int FLUSH_CYCLES = 4,
    parameter int BOOT_RUN     = 0
) (
    input logic clk,
    input logic reset_n,
    hack_rom_loader_if.slave io
);
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;
    localparam logic [24:0] DEPTH_W = 25'(DEPTH);
    localparam logic [7:0]  FC_LAST = 8'(FLUSH_CYCLES - 1);
    logic [15:0] mem [DEPTH];
    logic [15:0] rd_q;
    state_t state_q, state_d;
    logic cpu_reset_q, cpu_reset_d, load_done_q, load_done_d, ovf_q, ovf_d;
    logic pend_q, pend_d, dl_q, dl_d, vld_q, vld_d;
    logic [15:0] wc_q, wc_d, wc_inc, wdata;
    logic [7:0] hi_q, hi_d, fc_q, fc_d;
    logic [ADDR_W-1:0] hi_addr_q, hi_addr_d, waddr, waddr_in;
    logic we, in_rng;
    assign wc_inc   = (wc_q == 16'hFFFF) ? wc_q : wc_q + 16'd1;
    assign waddr_in = io.ioctl_addr[ADDR_W:1];
    assign in_rng   = {1'b0, io.ioctl_addr[24:1]} < DEPTH_W;
    assign vld_d    = state_d == RUN;
    always_comb begin
        state_d     = state_q;
        cpu_reset_d = cpu_reset_q;
        load_done_d = load_done_q;
        wc_d        = wc_q;
        ovf_d       = ovf_q;
        hi_d        = hi_q;
        hi_addr_d   = hi_addr_q;
        pend_d      = pend_q;
        fc_d        = fc_q;
        dl_d        = dl_q;
        we          = 1'b0;
        waddr       = hi_addr_q;
        wdata       = {hi_q, 8'h00};
        if (state_q != LOAD && io.ioctl_download) begin
            state_d     = LOAD;
            cpu_reset_d = 1'b1;
            wc_d        = '0;
            ovf_d       = 1'b0;
            pend_d      = 1'b0;
            dl_d        = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (BOOT_RUN != 0) begin
                    state_d = FLUSH;
                    fc_d    = '0;
                end
                LOAD: if (!io.ioctl_download) begin
                    // a trailing even byte becomes a word with a zero low half
                    state_d = FLUSH;
                    fc_d    = '0;
                    pend_d  = 1'b0;
                    we      = pend_q;
                    wc_d    = pend_q ? wc_inc : wc_q;
                end else if (io.ioctl_wr) begin
                    if (!in_rng) ovf_d = 1'b1;
                    else if (!io.ioctl_addr[0]) begin
                        hi_d      = io.ioctl_dout;
                        hi_addr_d = waddr_in;
                        pend_d    = 1'b1;
                    end else begin
                        we     = 1'b1;
                        waddr  = waddr_in;
                        wdata  = {pend_q ? hi_q : 8'h00, io.ioctl_dout};
                        wc_d   = wc_inc;
                        pend_d = 1'b0;
                    end
                end
                FLUSH: if (fc_q == FC_LAST) begin
                    state_d     = RUN;
                    cpu_reset_d = 1'b0;
                    load_done_d = load_done_q | dl_q;
                end else fc_d = fc_q + 8'd1;
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cpu_reset_q <= 1'b1;
            load_done_q <= 1'b0;
            wc_q        <= '0;
            ovf_q       <= 1'b0;
            hi_q        <= '0;
            hi_addr_q   <= '0;
            pend_q      <= 1'b0;
            fc_q        <= '0;
            dl_q        <= 1'b0;
            vld_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpu_reset_q <= cpu_reset_d;
            load_done_q <= load_done_d;
            wc_q        <= wc_d;
            ovf_q       <= ovf_d;
            hi_q        <= hi_d;
            hi_addr_q   <= hi_addr_d;
            pend_q      <= pend_d;
            fc_q        <= fc_d;
            dl_q        <= dl_d;
            vld_q       <= vld_d;
        end
    end
    // ROM array has no reset so it maps onto block RAM; reads only fetch while running
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (vld_d) rd_q <= mem[io.pc];
    end
    assign io.instruction = vld_q ? rd_q : 16'h0000;
    assign io.cpu_reset   = cpu_reset_q;
    assign io.load_done   = load_done_q;
    assign io.word_count  = wc_q;
    assign io.overflow    = ovf_q;
endmodule

// File: tb/tb_hack_rom_loader.sv
// tb_hack_rom_loader: table-driven fetch checks with a scoreboard queue plus download/reset sequences.
module tb_hack_rom_loader;
    localparam int DEPTH = 32768;
    localparam int FLUSH = 4;
    typedef struct {
        int          ph;
        logic [14:0] pc;
        logic [15:0] exp;
    } vec_t;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [15:0] sb[$];
    vec_t vt[$];
    hack_rom_loader_if #(.ADDR_W(15)) io ();
    hack_rom_loader #(.ADDR_W(15), .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH), .BOOT_RUN(0))
        dut (.clk(clk), .reset_n(reset_n), .io(io));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask
    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        io.ioctl_wr = 1'b1;
        io.ioctl_addr = a;
        io.ioctl_dout = d;
        tick();
        io.ioctl_wr = 1'b0;
    endtask
    task automatic dl_start();
        io.ioctl_download = 1'b1;
        tick();
        chk("load_cpu_reset", 32'(io.cpu_reset), 32'd1);
        chk("load_instr", 32'(io.instruction), 32'h0);
    endtask
    task automatic dl_end();
        int n;
        n = -1;
        io.ioctl_download = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (!io.cpu_reset) begin
                n = i;
                break;
            end
        end
        chk("flush_len", 32'(n), 32'(FLUSH + 1));
        chk("load_done", 32'(io.load_done), 32'd1);
    endtask
    task automatic fetch(input logic [14:0] p, input logic [15:0] e);
        io.pc = p;
        sb.push_back(e);
        tick();
        if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
        else chk("fetch", 32'(io.instruction), 32'(sb.pop_front()));
    endtask
    task automatic run_phase(input int p);
        for (int i = 0; i < vt.size(); i++)
            if (vt[i].ph == p) fetch(vt[i].pc, vt[i].exp);
    endtask
    initial begin
        vt.push_back('{1, 15'd0, 16'h0005});
        vt.push_back('{1, 15'd1, 16'hEC10});
        vt.push_back('{1, 15'd0, 16'h0005});
        vt.push_back('{2, 15'd0, 16'hABCD});
        vt.push_back('{2, 15'd1, 16'h1200});
        vt.push_back('{3, 15'd0, 16'hABCD});
        vt.push_back('{3, 15'd5, 16'h1234});
        vt.push_back('{3, 15'd6, 16'h5678});
        vt.push_back('{3, 15'd1, 16'h1200});
        vt.push_back('{4, 15'd0, 16'hDEAD});
        vt.push_back('{4, 15'd1, 16'h1200});
        vt.push_back('{4, 15'd5, 16'h1234});
        vt.push_back('{4, 15'd6, 16'h5678});
        vt.push_back('{5, 15'd0, 16'hDEAD});
        vt.push_back('{5, 15'd1, 16'h0FF0});
        io.ioctl_download = 1'b0;
        io.ioctl_wr = 1'b0;
        io.ioctl_addr = '0;
        io.ioctl_dout = '0;
        io.pc = '0;
        tick();
        tick();
        chk("rst_cpu_reset", 32'(io.cpu_reset), 32'd1);
        chk("rst_instr", 32'(io.instruction), 32'h0);
        chk("rst_load_done", 32'(io.load_done), 32'd0);
        chk("rst_wc", 32'(io.word_count), 32'd0);
        chk("rst_ovf", 32'(io.overflow), 32'd0);
        reset_n = 1'b1;
        repeat (100) tick();
        chk("idle_cpu_reset", 32'(io.cpu_reset), 32'd1);
        chk("idle_instr", 32'(io.instruction), 32'h0);
        chk("idle_load_done", 32'(io.load_done), 32'd0);
        // first program
        dl_start();
        wr_byte(25'd0, 8'h00);
        wr_byte(25'd1, 8'h05);
        wr_byte(25'd2, 8'hEC);
        wr_byte(25'd3, 8'h10);
        dl_end();
        chk("p1_wc", 32'(io.word_count), 32'd2);
        chk("p1_ovf", 32'(io.overflow), 32'd0);
        run_phase(1);
        // odd-length program, started from RUN
        dl_start();
        wr_byte(25'd0, 8'hAB);
        wr_byte(25'd1, 8'hCD);
        wr_byte(25'd2, 8'h12);
        dl_end();
        chk("p2_wc", 32'(io.word_count), 32'd2);
        run_phase(2);
        // out-of-range bytes plus words 5 and 6
        dl_start();
        wr_byte(25'(2 * DEPTH), 8'h77);
        wr_byte(25'(2 * DEPTH + 1), 8'h88);
        chk("p3_ovf_mid", 32'(io.overflow), 32'd1);
        chk("p3_wc_mid", 32'(io.word_count), 32'd0);
        wr_byte(25'd10, 8'h12);
        wr_byte(25'd11, 8'h34);
        wr_byte(25'd12, 8'h56);
        wr_byte(25'd13, 8'h78);
        dl_end();
        chk("p3_wc", 32'(io.word_count), 32'd2);
        chk("p3_ovf", 32'(io.overflow), 32'd1);
        run_phase(3);
        // download arriving while the CPU fetches
        io.pc = 15'd5;
        tick();
        chk("run_instr", 32'(io.instruction), 32'h1234);
        io.pc = 15'd6;
        dl_start();
        chk("p4_ovf_clr", 32'(io.overflow), 32'd0);
        wr_byte(25'd0, 8'hDE);
        wr_byte(25'd1, 8'hAD);
        dl_end();
        chk("p4_wc", 32'(io.word_count), 32'd1);
        run_phase(4);
        // reset in the middle of a load with a pending even byte
        dl_start();
        wr_byte(25'd0, 8'h99);
        reset_n = 1'b0;
        io.ioctl_download = 1'b0;
        #1;
        chk("mid_rst_cpu_reset", 32'(io.cpu_reset), 32'd1);
        chk("mid_rst_load_done", 32'(io.load_done), 32'd0);
        chk("mid_rst_wc", 32'(io.word_count), 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        chk("post_rst_cpu_reset", 32'(io.cpu_reset), 32'd1);
        chk("post_rst_instr", 32'(io.instruction), 32'h0);
        dl_start();
        wr_byte(25'd2, 8'h0F);
        wr_byte(25'd3, 8'hF0);
        dl_end();
        chk("p5_wc", 32'(io.word_count), 32'd1);
        run_phase(5);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
